led_pattern_sequencer: RTL



---
 rtl/led_seq_pkg.sv | 14 +
 rtl/tick_gen.sv | 38 +++
 rtl/led_pattern_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encodings for the LED pattern sequencer.
// Imported by led_pattern_sequencer and its testbench.
package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every INPUT_CLOCK/OUTPUT_HZ
// enabled cycles; i_clr restarts the interval from zero.
module tick_gen #(
  parameter int INPUT_CLOCK = 27000000,
  parameter int OUTPUT_HZ   = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DIV = INPUT_CLOCK / OUTPUT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("tick_gen: INPUT_CLOCK/OUTPUT_HZ must be >= 2");
  end

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap   = (count == LAST);
  assign o_tick = i_en && !i_clr && wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps a selectable LED pattern at STEP_HZ.
// Define LED_SEQ_CMD_IMMEDIATE_EN to apply commands without waiting for a tick.
import led_seq_pkg::*;

module led_pattern_sequencer #(
  parameter int INPUT_CLOCK = 27000000,
  parameter int STEP_HZ     = 2,
  parameter int LED_WIDTH   = 6,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  input  logic [MODE_W-1:0] i_cmd_mode,
  output logic              o_cmd_ready,
  input  logic              i_pause,
  output logic              o_step,
  output logic [MODE_W-1:0] o_mode,
  output logic [LED_WIDTH-1:0] o_leds
);

  localparam int W = LED_WIDTH;

  if (W < 2) begin : g_width_check
    $error("led_pattern_sequencer: LED_WIDTH must be >= 2");
  end

  logic         tick;
  logic         accept;
  logic         clr;
  logic         pending;
  logic         step_q;
  logic         dir;
  logic         dir_next;
  mode_e        mode;
  logic [W-1:0] pattern;
  logic [W-1:0] pat_next;

  function automatic logic [W-1:0] init_pat(input mode_e m);
    return (m == MODE_SCAN) ? W'(1) : '0;
  endfunction

  tick_gen #(
    .INPUT_CLOCK(INPUT_CLOCK),
    .OUTPUT_HZ  (STEP_HZ)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (!i_pause),
    .i_clr  (clr),
    .o_tick (tick)
  );

  // dir = 1 means the scan dot moves toward the MSB
  always_comb begin
    pat_next = pattern;
    dir_next = dir;
    unique case (mode)
      MODE_COUNT: pat_next = pattern + W'(1);
      MODE_SCAN: begin
        if (dir) begin
          if (pattern[W-1]) begin
            pat_next = pattern >> 1;
            dir_next = 1'b0;
          end else begin
            pat_next = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            pat_next = pattern << 1;
            dir_next = 1'b1;
          end else begin
            pat_next = pattern >> 1;
          end
        end
      end
      MODE_BLINK: pat_next = ~pattern;
      MODE_FILL:
        pat_next = (&pattern) ? '0 : {pattern[W-2:0], 1'b1};
      default: pat_next = pattern;
    endcase
  end

`ifdef LED_SEQ_CMD_IMMEDIATE_EN
  assign accept  = i_cmd_valid;
  assign clr     = accept;
  assign pending = 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode    <= MODE_COUNT;
      pattern <= '0;
      dir     <= 1'b1;
    end else if (accept) begin
      mode    <= mode_e'(i_cmd_mode);
      pattern <= init_pat(mode_e'(i_cmd_mode));
      dir     <= 1'b1;
    end else if (tick) begin
      pattern <= pat_next;
      dir     <= dir_next;
    end
  end
`else
  mode_e pending_mode;

  assign accept = i_cmd_valid && !pending;
  assign clr    = 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending      <= 1'b0;
      pending_mode <= MODE_COUNT;
    end else if (tick && pending) begin
      pending      <= 1'b0;
    end else if (accept) begin
      pending      <= 1'b1;
      pending_mode <= mode_e'(i_cmd_mode);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode    <= MODE_COUNT;
      pattern <= '0;
      dir     <= 1'b1;
    end else if (tick) begin
      if (pending) begin
        mode    <= pending_mode;
        pattern <= init_pat(pending_mode);
        dir     <= 1'b1;
      end else begin
        pattern <= pat_next;
        dir     <= dir_next;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) step_q <= 1'b0;
    else          step_q <= tick;
  end

  assign o_cmd_ready = !pending;
  assign o_step      = step_q;
  assign o_mode      = mode;
  assign o_leds      = (ACTIVE_LOW != 0) ? ~pattern : pattern;

endmodule
